onchip_mem_stream_reader: RTL and testbench

Avalon-MM read master that sits directly upstream of the 32-bit single-port on-chip memory. On a start command it fetches a run of consecutive words and presents them on a valid/ready stream, for example to the display pixel path. It exploits the memory's fixed 1-cycle read latency with no waitrequest, and buffers returns in a small FIFO so the consumer can stall without losing data.

---
 rtl/onchip_mem_stream_reader.sv | 160 ++++++++++++++++
 tb/tb_onchip_mem_stream_reader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_stream_reader.sv
// onchip_mem_stream_reader
//   Avalon-MM read master for a 32-bit single-port on-chip memory with a fixed
//   1-cycle read latency and no waitrequest. A start command fetches a run of
//   consecutive words, wrapping at MEM_WORDS. The words go out on a
//   valid/ready stream through a small FIFO, so the consumer can stall without
//   losing data.
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start/base_addr/length run command, sampled only in IDLE
//   abort                 synchronous cancel of a run in progress
//   busy, done            run status; done is a one-cycle completion pulse
//   mem_*                 Avalon-MM master (chipselect with write=0 is a read)
//   out_data/valid/ready  output stream taken from the FIFO head
module onchip_mem_stream_reader #(
  parameter int MEM_WORDS  = 5000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [12:0] base_addr,
  input  logic [12:0] length,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [12:0] mem_address,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic        mem_clken,
  input  logic [31:0] mem_readdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int AW     = 13;
  localparam int DW     = 32;
  localparam int STAGES = 1;  // memory read latency
  localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = PW + 1;
  localparam int OW     = CW + 2;
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, remaining_q, mem_address_q;
  logic [AW-1:0]   src_addr, src_rem;
  // vld_pipe[0] is the registered chipselect (read issued this cycle),
  // vld_pipe[STAGES] marks that mem_readdata holds a return this cycle.
  logic [STAGES:0] vld_pipe;
  logic            busy_q;
  logic            flush, push, pop, launch, issue_d;
  logic [OW-1:0]   occ_next;

  logic [DW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_count;

  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign mem_chipselect = vld_pipe[0];
  assign mem_address    = mem_address_q;
  assign busy           = busy_q;
  assign out_valid      = (fifo_count != '0);
  assign out_data       = fifo_mem[rd_ptr];

  // Chipselect is registered, so the issue decision for cycle N+1 is made in
  // cycle N from what occupancy will be then: FIFO count after this cycle's
  // push/pop, plus the read issued now (in flight next cycle), plus the new
  // read itself.
  always_comb begin
    flush    = abort && (state_q == S_RUN || state_q == S_DRAIN);
    pop      = out_valid && out_ready;
    push     = vld_pipe[STAGES] && !flush;
    launch   = (state_q == S_IDLE) && start && (length != '0);
    src_addr = launch ? base_addr : addr_q;
    src_rem  = launch ? length : remaining_q;
    occ_next = OW'(fifo_count) + OW'(push) + OW'(vld_pipe[0]) + OW'(1) - OW'(pop);
    issue_d  = !flush && (launch || state_q == S_RUN) && (src_rem != '0) &&
               (occ_next <= OW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = (length == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (abort)                  state_d = S_DONE;
        else if (remaining_q == '0) state_d = S_DRAIN;
      end
      // Leave one cycle early when the last word is being accepted now, so
      // done lands in the cycle right after that accept.
      S_DRAIN: begin
        if (abort) state_d = S_DONE;
        else if (vld_pipe == '0 && fifo_count == CW'(pop)) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe      <= '0;
      addr_q        <= '0;
      remaining_q   <= '0;
      mem_address_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      // An abort kills the read issued in the abort cycle, so its return
      // is never captured.
      vld_pipe <= {vld_pipe[STAGES-1:0] & {STAGES{!flush}}, issue_d};
      if (flush) begin
        remaining_q <= '0;
      end else if (issue_d) begin
        mem_address_q <= src_addr;
        addr_q        <= (src_addr == LAST_ADDR) ? '0 : src_addr + AW'(1);
        remaining_q   <= src_rem - AW'(1);
      end else if (launch) begin
        addr_q      <= base_addr;
        remaining_q <= length;
      end
      // A zero-length run goes straight to DONE without ever raising busy.
      if (launch)                busy_q <= 1'b1;
      else if (state_q == S_DONE) busy_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= mem_readdata;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// tb_onchip_mem_stream_reader
//   Directed bench for onchip_mem_stream_reader. A behavioural memory answers
//   reads one cycle after chipselect. The expected stream for each run is
//   built as a queue of mem[(base+k) % MEM_WORDS], and an address queue is
//   built the same way. A negedge monitor pops and compares these queues on
//   every chipselect and on every accepted word. Run-level timing is checked
//   against hand-computed cycle offsets.
module tb_onchip_mem_stream_reader;
  localparam int MEM_WORDS  = 5000;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [12:0] base_addr = '0, length = '0;
  logic        busy, done, mem_chipselect, mem_write, mem_clken, out_valid;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata = '0, out_data;

  always #5 clk = ~clk;

  onchip_mem_stream_reader #(.MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .length(length), .abort(abort), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_byteenable(mem_byteenable), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  logic [31:0] mem [MEM_WORDS];
  always @(posedge clk)
    if (mem_chipselect && !mem_write && mem_address < 13'(MEM_WORDS))
      mem_readdata <= mem[mem_address];

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  int          addr_exp[$];
  int cs_cnt, done_cnt, done_cyc, first_cs, first_valid, busy_rise, busy_fall;
  int issued, accepted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not expected / not seen", name);
  endtask

  task automatic prep(input int b, input int l);
    exp_q.delete();
    addr_exp.delete();
    for (int k = 0; k < l; k++) begin
      addr_exp.push_back((b + k) % MEM_WORDS);
      exp_q.push_back(mem[(b + k) % MEM_WORDS]);
    end
    cs_cnt = 0; done_cnt = 0; done_cyc = -1; first_cs = -1; first_valid = -1;
    busy_rise = -1; busy_fall = -1; issued = 0; accepted = 0;
  endtask

  // Sample everything mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("tied_signals", 32'({mem_write, mem_byteenable, mem_clken}), 32'b011111);
      if (mem_chipselect) begin
        cs_cnt++;
        issued++;
        if (first_cs < 0) first_cs = cyc;
        if (addr_exp.size() == 0) fail("spare_chipselect");
        else chk("mem_address", 32'(mem_address), 32'(addr_exp.pop_front()));
        chk("occupancy_le_depth", 32'(issued - accepted <= FIFO_DEPTH), 32'd1);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy && busy_rise < 0) busy_rise = cyc;
      if (!busy && busy_rise >= 0 && busy_fall < 0) busy_fall = cyc;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) begin
        accepted++;
        if (exp_q.size() == 0) fail("spare_word");
        else chk("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic do_start(input int b, input int l, output int t);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 13'(b); length = 13'(l);
    t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input bit bp);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin
      @(posedge clk); #1;
      if (bp) out_ready = ($urandom_range(0, 99) < 30);
      n++;
    end
    if (done_cnt == 0) fail("done_timeout");
  endtask

  task automatic run_basic();
    int t;
    prep(10, 8);
    chk("model_pin_first", exp_q[0], 32'd30);
    chk("model_pin_last", exp_q[7], 32'd51);
    out_ready = 1'b1;
    do_start(10, 8, t);
    wait_done(200, 1'b0);
    repeat (3) @(posedge clk);
    chk("basic_first_cs", 32'(first_cs), 32'(t + 1));
    chk("basic_busy_rise", 32'(busy_rise), 32'(t + 1));
    chk("basic_first_valid", 32'(first_valid), 32'(t + 3));
    chk("basic_cs_count", 32'(cs_cnt), 32'd8);
    chk("basic_done_cycle", 32'(done_cyc), 32'(t + 11));
    chk("basic_busy_fall", 32'(busy_fall), 32'(t + 12));
    chk("basic_done_count", 32'(done_cnt), 32'd1);
    chk("basic_words_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int t, t2;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'(i * 3);

    // reset values
    #12;
    chk("reset_outputs", 32'({busy, done, mem_chipselect, out_valid}), 32'd0);
    chk("reset_address", 32'(mem_address), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    #10 reset_n = 1'b1;

    // basic read
    run_basic();

    // wrap-around
    prep(4998, 4);
    chk("model_pin_wrap_addr", 32'(addr_exp[2]), 32'd0);
    chk("model_pin_wrap_data", exp_q[1], 32'd14997);
    do_start(4998, 4, t);
    wait_done(200, 1'b0);
    repeat (3) @(posedge clk);
    chk("wrap_cs_count", 32'(cs_cnt), 32'd4);
    chk("wrap_words_left", 32'(exp_q.size()), 32'd0);
    chk("wrap_done_count", 32'(done_cnt), 32'd1);

    // backpressure
    prep(100, 20);
    do_start(100, 20, t);
    wait_done(2000, 1'b1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    chk("bp_cs_count", 32'(cs_cnt), 32'd20);
    chk("bp_accepted", 32'(accepted), 32'd20);
    chk("bp_words_left", 32'(exp_q.size()), 32'd0);

    // zero length
    prep(0, 0);
    do_start(0, 0, t);
    repeat (3) @(posedge clk);
    chk("zero_done_cycle", 32'(done_cyc), 32'(t + 1));
    chk("zero_done_count", 32'(done_cnt), 32'd1);
    chk("zero_cs_count", 32'(cs_cnt), 32'd0);
    chk("zero_busy_never", 32'(busy_rise), 32'hFFFF_FFFF);

    // start while busy is ignored
    prep(200, 16);
    do_start(200, 16, t);
    do_start(0, 5, t2);
    wait_done(300, 1'b0);
    repeat (3) @(posedge clk);
    chk("busy_start_cs_count", 32'(cs_cnt), 32'd16);
    chk("busy_start_accepted", 32'(accepted), 32'd16);
    chk("busy_start_done_count", 32'(done_cnt), 32'd1);

    // abort with the consumer stalled
    out_ready = 1'b0;
    prep(300, 100);
    do_start(300, 100, t);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("abort_first_valid", 32'(first_valid), 32'(t + 3));
    chk("abort_done_cycle", 32'(done_cyc), 32'(t + 4));
    chk("abort_done_count", 32'(done_cnt), 32'd1);
    chk("abort_cs_count", 32'(cs_cnt), 32'd3);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    prep(0, 2);
    do_start(0, 2, t);
    wait_done(100, 1'b0);
    repeat (3) @(posedge clk);
    chk("post_abort_accepted", 32'(accepted), 32'd2);
    chk("post_abort_words_left", 32'(exp_q.size()), 32'd0);

    // asynchronous reset mid-run
    prep(10, 8);
    do_start(10, 8, t);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_status", 32'({busy, done, mem_chipselect, out_valid}), 32'd0);
    chk("async_rst_address", 32'(mem_address), 32'd0);
    chk("async_rst_out_data", out_data, 32'd0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'({busy, done, mem_chipselect, out_valid}), 32'd0);
    chk("post_rst_no_done", 32'(done_cnt), 32'd0);
    run_basic();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
